// File: rtl/irq_nest_ctrl.sv
// Interrupt preemption/nesting controller: priority arbitration, entry handshake,
// and return-stack sequencing with nesting-depth guarding.
module irq_nest_ctrl #(
  parameter int unsigned NumIrq     = 8,
  parameter int unsigned PrioWidth  = 3,
  parameter int unsigned PcWidth    = 32,
  parameter int unsigned StackDepth = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NumIrq-1:0]             irq_pending,
  input  logic [NumIrq*PrioWidth-1:0]   irq_prio,
  input  logic                          irq_enable,
  input  logic [PcWidth-1:0]            pc_in,
  input  logic                          entry_ack,
  input  logic                          mret,
  output logic                          entry_req,
  output logic [$clog2(NumIrq)-1:0]     entry_id,
  output logic [NumIrq-1:0]             irq_clear,
  output logic                          ret_valid,
  output logic [PcWidth-1:0]            ret_pc,
  output logic [PrioWidth-1:0]          cur_prio,
  output logic [$clog2(StackDepth)-1:0] depth,
  output logic                          nest_full,
  output logic                          underflow,
  output logic                          stack_reset,
  output logic                          stack_push,
  output logic                          stack_pop,
  output logic [PrioWidth+PcWidth-1:0]  stack_wdata,
  input  logic [PrioWidth+PcWidth-1:0]  stack_rdata
);

  localparam int unsigned IdW  = $clog2(NumIrq);
  localparam int unsigned DepW = $clog2(StackDepth);
  localparam logic [DepW-1:0] DepMax = DepW'(StackDepth - 1);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_PUSH = 2'd2;
  localparam logic [1:0] ST_POP  = 2'd3;

  logic [1:0]           state;
  logic [PrioWidth-1:0] win_prio;
  logic [PcWidth-1:0]   cap_pc;
  logic                 mret_pend;

  logic                 cand_valid;
  logic [IdW-1:0]       cand_id;
  logic [PrioWidth-1:0] cand_prio;
  logic                 eligible;
  logic                 accept;

  // Highest priority pending line; strict compare keeps the lowest index on ties.
  always_comb begin
    cand_valid = 1'b0;
    cand_id    = '0;
    cand_prio  = '0;
    for (int unsigned i = 0; i < NumIrq; i++) begin
      if (irq_pending[i] &&
          (!cand_valid || (irq_prio[i*PrioWidth +: PrioWidth] > cand_prio))) begin
        cand_valid = 1'b1;
        cand_id    = IdW'(i);
        cand_prio  = irq_prio[i*PrioWidth +: PrioWidth];
      end
    end
  end

  assign nest_full = (depth == DepMax);
  assign eligible  = irq_enable && cand_valid && (cand_prio > cur_prio) &&
                     !nest_full && !mret_pend;
  assign accept    = entry_req && entry_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_INIT;
      entry_req <= 1'b0;
      entry_id  <= '0;
      win_prio  <= '0;
      cap_pc    <= '0;
      cur_prio  <= '0;
      depth     <= '0;
      underflow <= 1'b0;
      mret_pend <= 1'b0;
    end else begin
      case (state)
        ST_INIT: state <= ST_IDLE;
        ST_IDLE: begin
          if (accept) begin
            entry_req <= 1'b0;
            cap_pc    <= pc_in;
            state     <= ST_PUSH;
            if (mret) mret_pend <= 1'b1;
          end else if (mret_pend) begin
            mret_pend <= 1'b0;
            if (depth != '0) state <= ST_POP;
            else             underflow <= 1'b1;
          end else if (mret && !entry_req) begin
            if (depth != '0) state <= ST_POP;
            else             underflow <= 1'b1;
          end else if (mret) begin
            mret_pend <= 1'b1;
          end else if (!entry_req && eligible) begin
            entry_req <= 1'b1;
            entry_id  <= cand_id;
            win_prio  <= cand_prio;
          end
        end
        ST_PUSH: begin
          cur_prio <= win_prio;
          if (depth != DepMax) depth <= depth + DepW'(1);
          // A return deferred across the entry goes straight to the pop.
          if (mret || mret_pend) begin
            mret_pend <= 1'b0;
            state     <= ST_POP;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_POP: begin
          cur_prio <= stack_rdata[PcWidth +: PrioWidth];
          if (depth != '0) depth <= depth - DepW'(1);
          if (mret) mret_pend <= 1'b1;
          if (accept) begin
            entry_req <= 1'b0;
            cap_pc    <= pc_in;
            state     <= ST_PUSH;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign stack_reset = (state == ST_INIT);
  assign stack_push  = (state == ST_PUSH);
  assign stack_pop   = (state == ST_POP);
  assign ret_valid   = stack_pop;
  assign ret_pc      = stack_pop  ? stack_rdata[PcWidth-1:0] : '0;
  assign stack_wdata = stack_push ? {cur_prio, cap_pc} : '0;

  always_comb begin
    irq_clear = '0;
    if (stack_push) irq_clear[entry_id] = 1'b1;
  end

endmodule

// File: tb/tb_irq_nest_ctrl.sv
// Bench for irq_nest_ctrl: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based model of the return stack and request flow.
module tb_irq_nest_ctrl;
  localparam int NI = 8, PW = 3, PCW = 32, SD = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [NI-1:0]       irq_pending = '0;
  logic [NI*PW-1:0]    irq_prio = '0;
  logic                irq_enable = 1'b0;
  logic [PCW-1:0]      pc_in = '0;
  logic                entry_ack = 1'b0;
  logic                mret = 1'b0;
  logic                entry_req;
  logic [2:0]          entry_id;
  logic [NI-1:0]       irq_clear;
  logic                ret_valid;
  logic [PCW-1:0]      ret_pc;
  logic [PW-1:0]       cur_prio;
  logic [1:0]          depth;
  logic                nest_full, underflow, stack_reset, stack_push, stack_pop;
  logic [PW+PCW-1:0]   stack_wdata, stack_rdata;

  always #5 clk = ~clk;

  irq_nest_ctrl #(.NumIrq(NI), .PrioWidth(PW), .PcWidth(PCW), .StackDepth(SD)) dut (
    .clk(clk), .reset(reset), .irq_pending(irq_pending), .irq_prio(irq_prio),
    .irq_enable(irq_enable), .pc_in(pc_in), .entry_ack(entry_ack), .mret(mret),
    .entry_req(entry_req), .entry_id(entry_id), .irq_clear(irq_clear),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .cur_prio(cur_prio), .depth(depth),
    .nest_full(nest_full), .underflow(underflow), .stack_reset(stack_reset),
    .stack_push(stack_push), .stack_pop(stack_pop), .stack_wdata(stack_wdata),
    .stack_rdata(stack_rdata));

  // Stack memory attached to the controller, wrapping silently.
  logic [PW+PCW-1:0] smem [SD];
  logic [1:0]        sp = '0;
  always @(posedge clk) begin
    if (stack_reset) sp <= '0;
    else if (stack_push) begin smem[sp] <= stack_wdata; sp <= sp + 2'd1; end
    else if (stack_pop) sp <= sp - 2'd1;
  end
  assign stack_rdata = smem[sp - 2'd1];

  int errors = 0, checks = 0;
  bit cmp_on = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: return stack as a queue of frames, one outstanding request.
  typedef struct { logic [PW-1:0] prio; logic [PCW-1:0] pc; } frame_t;
  frame_t         m_stack[$];
  bit             m_init, m_push, m_pop, m_req, m_mpend, m_uflow;
  int             m_id;
  logic [PW-1:0]  m_reqprio, m_cur;
  logic [PCW-1:0] m_reqpc;
  bit             m_ack, m_ret;

  task model_reset();
    m_stack.delete();
    m_init = 1; m_push = 0; m_pop = 0; m_req = 0; m_mpend = 0; m_uflow = 0;
    m_id = 0; m_reqprio = '0; m_cur = '0; m_reqpc = '0;
  endtask

  task take();
    m_req = 0; m_reqpc = pc_in; m_push = 1;
  endtask

  task arbitrate();
    int top, idx;
    top = -1; idx = -1;
    for (int i = 0; i < NI; i++)
      if (irq_pending[i] && int'(irq_prio[i*PW +: PW]) > top) top = int'(irq_prio[i*PW +: PW]);
    for (int i = NI - 1; i >= 0; i--)
      if (irq_pending[i] && int'(irq_prio[i*PW +: PW]) == top) idx = i;
    if (idx >= 0 && irq_enable && top > int'(m_cur) && m_stack.size() < SD - 1) begin
      m_req = 1; m_id = idx; m_reqprio = PW'(top);
    end
  endtask

  task model_step();
    if (!reset) return;
    if (m_init) begin m_init = 0; return; end
    m_ack = m_req && entry_ack;
    m_ret = 0;
    if (m_push) begin
      m_stack.push_back(frame_t'{m_cur, m_reqpc});
      m_cur = m_reqprio; m_push = 0;
      if (mret || m_mpend) begin m_mpend = 0; m_pop = 1; end
    end else if (m_pop) begin
      m_cur = m_stack[$].prio;
      void'(m_stack.pop_back());
      m_pop = 0;
      if (m_ack) take();
      if (mret) m_mpend = 1;
    end else begin
      if (m_ack) begin take(); if (mret) m_mpend = 1; end
      else if (m_mpend) begin m_mpend = 0; m_ret = 1; end
      else if (mret && !m_req) m_ret = 1;
      else if (mret) m_mpend = 1;
      else if (!m_req) arbitrate();
      if (m_ret) begin
        if (m_stack.size() > 0) m_pop = 1;
        else m_uflow = 1;
      end
    end
  endtask

  logic [PCW-1:0] e_retpc;
  always @(negedge clk) begin
    if (cmp_on) begin
      e_retpc = (m_pop && m_stack.size() > 0) ? m_stack[$].pc : '0;
      chk("entry_req", 64'(entry_req), 64'(m_req));
      if (m_req) chk("entry_id", 64'(entry_id), 64'(m_id));
      chk("irq_clear", 64'(irq_clear), m_push ? 64'(1) << m_id : 64'd0);
      chk("stack_push", 64'(stack_push), 64'(m_push));
      chk("stack_wdata", 64'(stack_wdata), m_push ? {29'd0, m_cur, m_reqpc} : 64'd0);
      chk("stack_pop", 64'(stack_pop), 64'(m_pop));
      chk("ret_valid", 64'(ret_valid), 64'(m_pop));
      chk("ret_pc", 64'(ret_pc), 64'(e_retpc));
      chk("cur_prio", 64'(cur_prio), 64'(m_cur));
      chk("depth", 64'(depth), 64'(m_stack.size()));
      chk("nest_full", 64'(nest_full), 64'(m_stack.size() == SD - 1));
      chk("underflow", 64'(underflow), 64'(m_uflow));
      chk("stack_reset", 64'(stack_reset), 64'(m_init));
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic hit_reset();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic set_line(input int line, input int p);
    irq_prio[line*PW +: PW] = PW'(p);
  endtask

  task automatic do_ret();
    mret = 1'b1; step(); mret = 1'b0; step();
  endtask

  task automatic do_entry(input int line, input int p, input logic [PCW-1:0] pc);
    set_line(line, p); irq_pending = NI'(1) << line; step();
    entry_ack = 1'b1; pc_in = pc; step();
    entry_ack = 1'b0; irq_pending = '0; step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1);
  end

  int since_mret;
  initial begin
    reset = 1'b1;
    #1 hit_reset();
    cmp_on = 1;
    step(); step();
    chk("rst_stack_reset", 64'(stack_reset), 64'd1);
    chk("rst_entry_req", 64'(entry_req), 64'd0);
    chk("rst_depth", 64'(depth), 64'd0);
    reset = 1'b1;
    chk("init_stack_reset", 64'(stack_reset), 64'd1);
    step();
    chk("idle_stack_reset", 64'(stack_reset), 64'd0);
    chk("idle_cur_prio", 64'(cur_prio), 64'd0);
    chk("idle_entry_req", 64'(entry_req), 64'd0);

    // Single entry: irq3 at prio 2
    set_line(3, 2); irq_pending = 8'h08; irq_enable = 1'b1;
    step();
    chk("a_entry_req", 64'(entry_req), 64'd1);
    chk("a_entry_id", 64'(entry_id), 64'd3);
    entry_ack = 1'b1; pc_in = 32'h100;
    step();
    chk("a_push", 64'(stack_push), 64'd1);
    chk("a_wdata", 64'(stack_wdata), 64'h100);
    chk("a_clear", 64'(irq_clear), 64'h08);
    entry_ack = 1'b0; irq_pending = '0;
    step();
    chk("a_cur_prio", 64'(cur_prio), 64'd2);
    chk("a_depth", 64'(depth), 64'd1);

    // Nesting: irq5 prio 4 preempts, irq1 prio 3 waits
    set_line(5, 4); set_line(1, 3); irq_pending = 8'h22;
    step();
    chk("b_entry_id", 64'(entry_id), 64'd5);
    entry_ack = 1'b1; pc_in = 32'h200; step();
    entry_ack = 1'b0; irq_pending = 8'h02; step();
    chk("b_cur_prio", 64'(cur_prio), 64'd4);
    step();
    chk("b_held_off", 64'(entry_req), 64'd0);
    mret = 1'b1; step(); mret = 1'b0;
    chk("b_ret_valid", 64'(ret_valid), 64'd1);
    chk("b_ret_pc", 64'(ret_pc), 64'h200);
    step();
    chk("b_cur_after_ret", 64'(cur_prio), 64'd2);
    step();
    chk("b_irq1_id", 64'(entry_id), 64'd1);
    entry_ack = 1'b1; pc_in = 32'h300; step();
    entry_ack = 1'b0; irq_pending = '0; step();
    chk("b_cur_irq1", 64'(cur_prio), 64'd3);
    do_ret(); do_ret();
    chk("b_unwound", 64'(depth), 64'd0);

    // Tie goes to lowest index, and the choice holds against a later winner
    set_line(2, 5); set_line(6, 5); irq_pending = 8'h44;
    step();
    chk("c_tie_id", 64'(entry_id), 64'd2);
    set_line(7, 6); irq_pending = 8'hC4;
    step();
    chk("c_hold_id", 64'(entry_id), 64'd2);
    entry_ack = 1'b1; pc_in = 32'h400; step();
    chk("c_clear", 64'(irq_clear), 64'h04);
    entry_ack = 1'b0; irq_pending = '0; step();
    do_ret();

    // Fill to StackDepth-1 and check blocking
    do_entry(0, 1, 32'h10); do_entry(1, 2, 32'h20); do_entry(2, 3, 32'h30);
    chk("d_nest_full", 64'(nest_full), 64'd1);
    set_line(7, 7); irq_pending = 8'h80; step(); step();
    chk("d_blocked", 64'(entry_req), 64'd0);
    mret = 1'b1; step(); mret = 1'b0; step();
    chk("d_not_full", 64'(nest_full), 64'd0);
    step();
    chk("d_proceeds", 64'(entry_req), 64'd1);
    entry_ack = 1'b1; pc_in = 32'h40; step();
    entry_ack = 1'b0; irq_pending = '0; step();
    chk("d_cur_prio", 64'(cur_prio), 64'd7);
    do_ret(); do_ret(); do_ret();
    chk("d_depth0", 64'(depth), 64'd0);

    // Return at depth 0
    mret = 1'b1; step(); mret = 1'b0;
    chk("e_underflow", 64'(underflow), 64'd1);
    chk("e_no_pop", 64'(stack_pop), 64'd0);
    step();
    chk("e_sticky", 64'(underflow), 64'd1);

    // Ack and mret together
    set_line(4, 3); irq_pending = 8'h10; step();
    entry_ack = 1'b1; mret = 1'b1; pc_in = 32'h500; step();
    chk("f_push", 64'(stack_push), 64'd1);
    entry_ack = 1'b0; mret = 1'b0; irq_pending = '0; step();
    chk("f_pop", 64'(stack_pop), 64'd1);
    chk("f_ret_pc", 64'(ret_pc), 64'h500);
    step();

    // Reset during a push aborts it
    set_line(0, 6); irq_pending = 8'h01; step();
    entry_ack = 1'b1; step();
    #2 hit_reset();
    #1;
    chk("g_abort_push", 64'(stack_push), 64'd0);
    chk("g_stack_reset", 64'(stack_reset), 64'd1);
    chk("g_underflow_clr", 64'(underflow), 64'd0);
    entry_ack = 1'b0; irq_pending = '0;
    step();
    reset = 1'b1;
    step();

    since_mret = 0;
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 3) == 0) irq_pending = NI'($urandom);
      if ($urandom_range(0, 5) == 0) irq_prio = (NI*PW)'($urandom);
      irq_enable = ($urandom_range(0, 9) != 0);
      entry_ack  = ($urandom_range(0, 2) == 0);
      pc_in      = $urandom;
      since_mret++;
      mret = 1'b0;
      if (since_mret >= 4 && $urandom_range(0, 6) == 0) begin
        mret = 1'b1; since_mret = 0;
      end
      if (c == 1200) begin
        hit_reset(); step(); step(); reset = 1'b1;
      end
      step();
    end
    mret = 1'b0; entry_ack = 1'b0;
    step();
    cmp_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
